// File: rtl/synth_pkg.sv
// Shared types and constants for the step sequencer: FSM states, pattern entry, gate fractions.
// Pure declarations; no logic, no latency, no backpressure.
package synth_pkg;

    typedef enum logic [1:0] {
        ST_STOP     = 2'd0,
        ST_GATE_ON  = 2'd1,
        ST_GATE_OFF = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic       en;
        logic [3:0] note;
    } step_entry_t;

    localparam logic [1:0] GATE_QUARTER   = 2'b00;
    localparam logic [1:0] GATE_HALF      = 2'b01;
    localparam logic [1:0] GATE_THREE_QTR = 2'b10;
    localparam logic [1:0] GATE_LEGATO    = 2'b11;

    // Tick count at which the gate closes; legato still leaves the last tick low.
    function automatic logic [8:0] gate_threshold(input logic [8:0] step_ticks,
                                                  input logic [1:0] gate_len);
        logic [8:0] thr;
        case (gate_len)
            GATE_QUARTER:   thr = step_ticks >> 2;
            GATE_HALF:      thr = step_ticks >> 1;
            GATE_THREE_QTR: thr = (step_ticks >> 1) + (step_ticks >> 2);
            default:        thr = step_ticks - 9'd1;
        endcase
        return thr;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Prescaler: one-cycle tick every CLKS_PER_TICK enabled cycles.
// Tick is combinational from the count register; no backpressure, count clears while en is low.
module tick_divider #(
    parameter int CLKS_PER_TICK = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_TICK - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/step_sequencer.sv
// Step sequencer: plays a programmable note/gate pattern into soundproc (tone_freq_bin, hold).
// Outputs registered, one cycle after the deciding event; no backpressure, run low stops next cycle.
module step_sequencer
    import synth_pkg::*;
#(
    parameter int STEPS         = 8,
    parameter int CLKS_PER_TICK = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [2:0] pat_len,
    input  logic [3:0] step_len,
    input  logic [1:0] gate_len,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [4:0] wr_data,
    output logic [3:0] tone_freq_bin,
    output logic       hold,
    output logic [2:0] step_idx,
    output logic       step_start
);

    step_entry_t pat_mem [STEPS];

    seq_state_t  state_q, state_d;
    logic        run_q;
    logic [7:0]  tick_cnt_q, tick_cnt_d;
    logic [2:0]  idx_d;
    logic [3:0]  tone_d;
    logic        hold_d;
    logic        start_d;
    logic        tick;

    logic [8:0]  step_ticks;
    logic [8:0]  gate_off_at;
    logic [8:0]  tick_inc;
    logic [2:0]  next_idx;
    step_entry_t first_entry;
    step_entry_t next_entry;

    tick_divider #(
        .CLKS_PER_TICK(CLKS_PER_TICK)
    ) u_tick_divider (
        .clk (clk),
        .rst (rst),
        .en  (state_q != ST_STOP),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STEPS; i++) begin
                pat_mem[i] <= '0;
            end
        end else if (wr_en) begin
            pat_mem[wr_addr] <= step_entry_t'(wr_data);
        end
    end

    assign step_ticks  = {1'b0, step_len, 4'b0000} + 9'd16;
    assign gate_off_at = gate_threshold(step_ticks, gate_len);
    assign tick_inc    = {1'b0, tick_cnt_q} + 9'd1;
    assign next_idx    = (step_idx >= pat_len) ? 3'd0 : step_idx + 3'd1;
    assign first_entry = pat_mem[0];
    assign next_entry  = pat_mem[next_idx];

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        idx_d      = step_idx;
        tone_d     = tone_freq_bin;
        hold_d     = hold;
        start_d    = 1'b0;

        if (!run) begin
            state_d    = ST_STOP;
            tick_cnt_d = 8'd0;
            hold_d     = 1'b0;
        end else begin
            case (state_q)
                ST_GATE_ON, ST_GATE_OFF: begin
                    if (tick) begin
                        // >= so a live shrink of step_len below the count ends the step on this tick
                        if (tick_inc >= step_ticks) begin
                            tick_cnt_d = 8'd0;
                            idx_d      = next_idx;
                            tone_d     = next_entry.note;
                            hold_d     = next_entry.en;
                            start_d    = 1'b1;
                            state_d    = next_entry.en ? ST_GATE_ON : ST_GATE_OFF;
                        end else begin
                            tick_cnt_d = tick_inc[7:0];
                            if (state_q == ST_GATE_ON && tick_inc == gate_off_at) begin
                                state_d = ST_GATE_OFF;
                                hold_d  = 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    if (!run_q) begin
                        tick_cnt_d = 8'd0;
                        idx_d      = 3'd0;
                        tone_d     = first_entry.note;
                        hold_d     = first_entry.en;
                        start_d    = 1'b1;
                        state_d    = first_entry.en ? ST_GATE_ON : ST_GATE_OFF;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_STOP;
            run_q         <= 1'b0;
            tick_cnt_q    <= 8'd0;
            step_idx      <= 3'd0;
            tone_freq_bin <= 4'd0;
            hold          <= 1'b0;
            step_start    <= 1'b0;
        end else begin
            state_q       <= state_d;
            run_q         <= run;
            tick_cnt_q    <= tick_cnt_d;
            step_idx      <= idx_d;
            tone_freq_bin <= tone_d;
            hold          <= hold_d;
            step_start    <= start_d;
        end
    end

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer with CLKS_PER_TICK=4 (16-tick steps are 64 clk).
module tb_step_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [2:0] pat_len;
    logic [3:0] step_len;
    logic [1:0] gate_len;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [4:0] wr_data;
    logic [3:0] tone_freq_bin;
    logic       hold;
    logic [2:0] step_idx;
    logic       step_start;

    int n_checks = 0;
    int n_fail   = 0;

    step_sequencer #(
        .STEPS(8),
        .CLKS_PER_TICK(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .pat_len      (pat_len),
        .step_len     (step_len),
        .gate_len     (gate_len),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .tone_freq_bin(tone_freq_bin),
        .hold         (hold),
        .step_idx     (step_idx),
        .step_start   (step_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write_step(input int addr, input int en, input int note);
        wr_en   = 1'b1;
        wr_addr = 3'(addr);
        wr_data = {1'(en), 4'(note)};
        cyc();
        wr_en   = 1'b0;
    endtask

    // Observes one 64-clk step starting on its step_start cycle; leaves us on the next step's first cycle.
    task automatic run_step(input string tag, input int exp_idx, input int exp_tone,
                            input int exp_hold_cnt, input int exp_en);
        int hc = 0, sc = 0, bad_idx = 0, bad_tone = 0;
        logic s0 = 1'b0, h0 = 1'b0, h63 = 1'b0;
        logic [2:0] i0 = 3'd0;
        logic [3:0] t0 = 4'd0;
        for (int t = 0; t < 64; t++) begin
            if (t == 0) begin
                s0 = step_start; h0 = hold; i0 = step_idx; t0 = tone_freq_bin;
            end
            if (t == 63) h63 = hold;
            hc += 32'(hold);
            sc += 32'(step_start);
            if (32'(step_idx) != exp_idx) bad_idx++;
            if (32'(tone_freq_bin) != exp_tone) bad_tone++;
            cyc();
        end
        check({tag, ".start_first"}, 32'(s0), 32'(1));
        check({tag, ".start_count"}, 32'(sc), 32'(1));
        check({tag, ".idx"}, 32'(i0), 32'(exp_idx));
        check({tag, ".idx_stray_cycles"}, 32'(bad_idx), 32'(0));
        check({tag, ".tone"}, 32'(t0), 32'(exp_tone));
        check({tag, ".tone_stray_cycles"}, 32'(bad_tone), 32'(0));
        check({tag, ".hold_cycles"}, 32'(hc), 32'(exp_hold_cnt));
        check({tag, ".hold_first"}, 32'(h0), 32'(exp_en));
        check({tag, ".hold_last"}, 32'(h63), 32'(0));
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; pat_len = 3'd7; step_len = 4'd0; gate_len = 2'b01;
        wr_en = 1'b0; wr_addr = 3'd0; wr_data = 5'd0;
        cyc();
        cyc();
        check("rst.tone", 32'(tone_freq_bin), 32'(0));
        check("rst.hold", 32'(hold), 32'(0));
        check("rst.idx", 32'(step_idx), 32'(0));
        check("rst.start", 32'(step_start), 32'(0));
        rst = 1'b0;
        cyc();

        // Full 8-step pattern, 50% gate, wraps back to note 1.
        for (int i = 0; i < 8; i++) write_step(i, 1, i + 1);
        run = 1'b1;
        cyc();
        for (int i = 0; i < 9; i++) run_step($sformatf("play%0d", i), i % 8, (i % 8) + 1, 32, 1);
        run = 1'b0;
        cyc();
        check("stop.hold", 32'(hold), 32'(0));
        check("stop.start", 32'(step_start), 32'(0));

        // Short pattern with a disabled step 1.
        pat_len = 3'd2;
        write_step(1, 0, 2);
        run = 1'b1;
        cyc();
        run_step("short0", 0, 1, 32, 1);
        run_step("short1", 1, 2, 0, 0);
        run_step("short2", 2, 3, 32, 1);
        run_step("short_wrap", 0, 1, 32, 1);
        run = 1'b0;
        cyc();

        // Legato: hold low only for the final tick (4 clk).
        write_step(1, 1, 2);
        pat_len  = 3'd7;
        gate_len = 2'b11;
        run = 1'b1;
        cyc();
        run_step("legato0", 0, 1, 60, 1);
        run_step("legato1", 1, 2, 60, 1);
        run = 1'b0;
        cyc();

        // Stop mid-step 3 and restart from step 0.
        gate_len = 2'b01;
        run = 1'b1;
        cyc();
        run_step("pre3_0", 0, 1, 32, 1);
        run_step("pre3_1", 1, 2, 32, 1);
        run_step("pre3_2", 2, 3, 32, 1);
        repeat (10) cyc();
        check("mid3.hold", 32'(hold), 32'(1));
        check("mid3.idx", 32'(step_idx), 32'(3));
        run = 1'b0;
        cyc();
        check("halt.hold", 32'(hold), 32'(0));
        check("halt.idx", 32'(step_idx), 32'(3));
        check("halt.tone", 32'(tone_freq_bin), 32'(4));
        check("halt.start", 32'(step_start), 32'(0));
        repeat (3) cyc();
        check("halted.idx", 32'(step_idx), 32'(3));
        run = 1'b1;
        cyc();
        check("resume.idx", 32'(step_idx), 32'(0));
        check("resume.start", 32'(step_start), 32'(1));
        check("resume.tone", 32'(tone_freq_bin), 32'(1));
        check("resume.hold", 32'(hold), 32'(1));
        repeat (5) cyc();

        // Reset during GATE_ON clears outputs and pattern memory.
        rst = 1'b1;
        cyc();
        check("midrst.tone", 32'(tone_freq_bin), 32'(0));
        check("midrst.hold", 32'(hold), 32'(0));
        check("midrst.idx", 32'(step_idx), 32'(0));
        check("midrst.start", 32'(step_start), 32'(0));
        rst = 1'b0; run = 1'b0;
        cyc();
        rst = 1'b1; run = 1'b1;
        cyc();
        check("rst_vs_run.start", 32'(step_start), 32'(0));
        check("rst_vs_run.hold", 32'(hold), 32'(0));
        rst = 1'b0; run = 1'b0;
        cyc();
        run = 1'b1;
        cyc();
        run_step("cleared0", 0, 0, 0, 0);
        run = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/step_sequencer.md
STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 Parameter STEPS, default 8: pattern depth; step index width is log2(STEPS).
REQ-002 Parameter CLKS_PER_TICK, default 1000: clk cycles per sequencer tick.
REQ-003 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port run, input, 1: level; high plays the pattern, low stops it.
REQ-006 Port pat_len, input, 3: pattern length is pat_len+1 steps.
REQ-007 Port step_len, input, 4: step duration is (step_len+1)*16 ticks.
REQ-008 Port gate_len, input, 2: gate duty; 00=25%, 01=50%, 10=75%, 11=legato.
REQ-009 Ports wr_en (1), wr_addr (3), wr_data (5), inputs: pattern write; wr_data = {enable, note[3:0]}.
REQ-010 Port tone_freq_bin, output, 4: registered note of the current step, fed to soundproc.
REQ-011 Port hold, output, 1: registered gate, fed to soundproc hold.
REQ-012 Port step_idx, output, 3: current step.
REQ-013 Port step_start, output, 1: one-cycle pulse on the first cycle of each step.

Function
REQ-014 Pattern memory: STEPS x 5-bit registers; a write lands on the cycle after wr_en is sampled high.
REQ-015 Prescaler counts 0..CLKS_PER_TICK-1 and pulses tick on terminal count; it is cleared while stopped.
REQ-016 Tick counter is 8-bit, 0..step_ticks-1, step_ticks = (step_len+1)*16; it advances only on tick.
REQ-017 States: STOP, GATE_ON, GATE_OFF; encoding lives in the package.
REQ-018 STOP->GATE_ON/GATE_OFF on a run rising edge (run high, previous run low): the next cycle has step_idx=0, step_start=1, tone_freq_bin=note[0], hold=enable[0].
REQ-019 Gate-off threshold: step_ticks/4, /2, 3/4 for 00/01/10; legato uses step_ticks-1.
REQ-020 GATE_ON->GATE_OFF on the tick where the incremented tick count equals the threshold; hold falls on the next cycle.
REQ-021 Step boundary is a tick with tick count = step_ticks-1: step_idx becomes step_idx+1, or 0 if step_idx >= pat_len; step_start pulses; the new note and enable load; the state re-enters GATE_ON or GATE_OFF.
REQ-022 A disabled step (enable=0) holds hold low for the whole step, and tone_freq_bin still updates.
REQ-023 Legato still drops hold for the final tick of each step, so the envelope retriggers every enabled step.
REQ-024 run low in any state: STOP next cycle, hold=0, step_start=0; step_idx and tone_freq_bin keep their last values.
REQ-025 A write to the step being loaded in the same cycle is not visible until that step's next visit.
REQ-026 step_len, gate_len and pat_len are sampled live; a shrink below the current tick count or step takes effect at the next boundary (REQ-021 wrap rule).
REQ-027 A run rising edge in the same cycle as rst: rst wins.

Reset
REQ-028 rst SHALL clear the pattern memory, prescaler, tick counter, state (STOP), tone_freq_bin=0, hold=0, step_idx=0, step_start=0 and the previous-run register, on the next clk edge.
REQ-029 rst mid-play SHALL stop within one cycle; resuming requires a fresh run rising edge.

Structure
REQ-030 A shared package synth_pkg SHALL hold the state enum, the 5-bit step-entry struct, and the gate-fraction constants.
REQ-031 The prescaler SHALL be a sub-module tick_divider (clk, rst, en, tick).
REQ-032 Target size is 150-300 lines of RTL; no division operators (shifts and adds only).

Verification (CLKS_PER_TICK=4)
REQ-033 Write notes 1..8, all enabled; pat_len=7, step_len=0, gate_len=01; raise run -> step_start every 64 clk, tone_freq_bin 1..8 then 1, hold high for 32 clk of each step.
REQ-034 pat_len=2 with steps 0-3 written -> step_idx sequence 0,1,2,0; step 3 never appears.
REQ-035 Step 1 enable=0 -> hold stays 0 for all 64 clk of step 1, and tone_freq_bin=2.
REQ-036 gate_len=11 -> hold is low only for the last 4 clk of each step and rises at each step_start.
REQ-037 Drop run mid-step 3 -> hold=0 next cycle, step_idx stays 3; re-raise run -> step_idx=0 one cycle later.
REQ-038 Assert rst during GATE_ON -> all outputs 0 next cycle and memory reads as 0 on the next run.
